// File: rtl/sram6t_rram_prog_pkg.sv
// sram6t_rram_prog_pkg: shared state encoding and bl/wl phase patterns for the RRAM programming sequencer
package sram6t_rram_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH1  = 3'd1,
        ST_GAP1 = 3'd2,
        ST_PH2  = 3'd3,
        ST_GAP2 = 3'd4,
        ST_DONE = 3'd5
    } prog_state_e;

    // Patterns are written leftmost-first: bit [0] is the leftmost line.
    localparam logic [0:2] BL_PH1_ZERO = 3'b100;
    localparam logic [0:2] BL_PH1_ONE  = 3'b010;
    localparam logic [0:2] BL_PH2      = 3'b001;
    localparam logic [0:2] WL_PH1      = 3'b001;
    localparam logic [0:2] WL_PH2_ZERO = 3'b100;
    localparam logic [0:2] WL_PH2_ONE  = 3'b010;

    function automatic logic [0:2] cell_wl(input logic b, input logic ph2);
        return ph2 ? (b ? WL_PH2_ONE : WL_PH2_ZERO) : WL_PH1;
    endfunction

    function automatic logic [0:2] cell_bl(input logic b, input logic ph2);
        return ph2 ? BL_PH2 : (b ? BL_PH1_ONE : BL_PH1_ZERO);
    endfunction

endpackage

// File: rtl/sram6t_rram_prog_timer.sv
// sram6t_rram_prog_timer: loadable down-counter timing the pulse and gap phases
//   prog_clock   : clock, rising edge
//   prog_reset_n : asynchronous active-low reset
//   i_load       : load i_load_val this cycle (takes priority over counting)
//   i_load_val   : cycles-minus-one of the phase being entered
//   o_zero       : count has reached zero, i.e. current phase is in its last cycle
module sram6t_rram_prog_timer
    import sram6t_rram_prog_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         prog_clock,
    input  logic         prog_reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge prog_clock or negedge prog_reset_n) begin
        if (!prog_reset_n)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (r_count != '0)
            r_count <= r_count - W'(1);
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram6t_rram_prog_ctrl.sv
// sram6t_rram_prog_ctrl: sequences two-phase bl/wl programming pulses over a row of sram6T_rram cells
//   prog_clock   : configuration clock, rising edge
//   prog_reset_n : asynchronous active-low reset
//   in_valid/in_ready/in_data : word handshake; in_data[i] programs cell i
//   abort        : drop the word in progress, back to IDLE without done
//   bl           : shared bit lines, [0:2] leftmost-first
//   wl           : word lines, cell i owns wl[3i +: 3]
//   busy         : word in progress
//   done         : one-cycle completion pulse
module sram6t_rram_prog_ctrl
    import sram6t_rram_prog_pkg::*;
#(
    parameter int NUM_CELLS    = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                     prog_clock,
    input  logic                     prog_reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CELLS-1:0]     in_data,
    input  logic                     abort,
    output logic [0:2]               bl,
    output logic [0:3*NUM_CELLS-1]   wl,
    output logic                     busy,
    output logic                     done
);

    localparam int TW = $clog2((PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES) + 1);
    localparam int CW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam logic [TW-1:0] P_LOAD    = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] G_LOAD    = TW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] LAST_CELL = CW'(NUM_CELLS - 1);

    prog_state_e                r_state;
    prog_state_e                w_next_state;
    logic [CW-1:0]              r_cell;
    logic [CW-1:0]              w_next_cell;
    logic [NUM_CELLS-1:0]       r_data;
    logic [NUM_CELLS-1:0]       w_src;
    logic                       r_armed;
    logic                       r_busy;
    logic                       r_done;
    logic [0:2]                 r_bl;
    logic [0:2]                 w_next_bl;
    logic [0:3*NUM_CELLS-1]     r_wl;
    logic [0:3*NUM_CELLS-1]     w_next_wl;
    logic [0:3*NUM_CELLS-1]     w_cell_mask;
    logic                       w_accept;
    logic                       w_busy_st;
    logic                       w_zero;
    logic                       w_load;
    logic                       w_next_ph;
    logic                       w_next_ph2;
    logic                       w_next_busy;
    logic                       w_next_bit;

    // r_armed keeps in_ready low until the first edge after reset release.
    assign in_ready    = r_armed && (r_state == ST_IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_busy_st   = (r_state == ST_PH1) || (r_state == ST_GAP1) ||
                         (r_state == ST_PH2) || (r_state == ST_GAP2);
    assign w_next_ph   = (w_next_state == ST_PH1) || (w_next_state == ST_PH2);
    assign w_next_ph2  = (w_next_state == ST_PH2);
    assign w_next_busy = w_next_ph || (w_next_state == ST_GAP1) || (w_next_state == ST_GAP2);
    // Every state change starts a new timed phase; DONE/IDLE ignore the timer.
    assign w_load      = (w_next_state != r_state);

    // abort outranks timer expiry in every busy state.
    always_comb begin
        w_next_state = r_state;
        w_next_cell  = r_cell;
        if (w_busy_st && abort)
            w_next_state = ST_IDLE;
        else
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    w_next_state = ST_PH1;
                    w_next_cell  = '0;
                end
                ST_PH1:  if (w_zero) w_next_state = ST_GAP1;
                ST_GAP1: if (w_zero) w_next_state = ST_PH2;
                ST_PH2:  if (w_zero) w_next_state = ST_GAP2;
                ST_GAP2: if (w_zero) begin
                    if (r_cell != LAST_CELL) begin
                        w_next_state = ST_PH1;
                        w_next_cell  = r_cell + CW'(1);
                    end else
                        w_next_state = ST_DONE;
                end
                default: w_next_state = ST_IDLE;
            endcase
    end

    // The accept edge already drives the first PH1, so the bit comes straight from in_data then.
    always_comb begin
        w_src       = w_accept ? in_data : r_data;
        w_next_bit  = 1'b0;
        w_next_wl   = '0;
        w_cell_mask = '0;
        for (int i = 0; i < NUM_CELLS; i++)
            if (CW'(i) == w_next_cell)
                w_next_bit = w_src[i];
        w_next_bl = w_next_ph ? cell_bl(w_next_bit, w_next_ph2) : 3'b000;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (w_next_ph && CW'(i) == w_next_cell)
                w_next_wl[3*i +: 3] = cell_wl(w_next_bit, w_next_ph2);
            if (CW'(i) == r_cell)
                w_cell_mask[3*i +: 3] = 3'b111;
        end
    end

    sram6t_rram_prog_timer #(
        .W (TW)
    ) u_timer (
        .prog_clock   (prog_clock),
        .prog_reset_n (prog_reset_n),
        .i_load       (w_load),
        .i_load_val   (w_next_ph ? P_LOAD : G_LOAD),
        .o_zero       (w_zero)
    );

    always_ff @(posedge prog_clock or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state <= ST_IDLE;
            r_cell  <= '0;
            r_data  <= '0;
            r_armed <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bl    <= '0;
            r_wl    <= '0;
        end else begin
            r_state <= w_next_state;
            r_cell  <= w_next_cell;
            if (w_accept)
                r_data <= in_data;
            r_armed <= 1'b1;
            r_busy  <= w_next_busy;
            r_done  <= (w_next_state == ST_DONE);
            r_bl    <= w_next_bl;
            r_wl    <= w_next_wl;
        end
    end

    assign bl   = r_bl;
    assign wl   = r_wl;
    assign busy = r_busy;
    assign done = r_done;

    a_onehot: assert property (@(posedge prog_clock) disable iff (!prog_reset_n)
        $onehot0(r_bl) && $onehot0(r_wl));
    a_cell: assert property (@(posedge prog_clock) disable iff (!prog_reset_n)
        (r_wl & ~w_cell_mask) == '0);
    a_pair: assert property (@(posedge prog_clock) disable iff (!prog_reset_n)
        (r_bl == '0) == (r_wl == '0));
    // Two consecutive active cycles must be the same phase, so distinct phases are separated by zeros.
    a_gap: assert property (@(posedge prog_clock) disable iff (!prog_reset_n)
        (r_bl != '0 && $past(r_bl) != '0) |-> (r_bl == $past(r_bl) && r_wl == $past(r_wl)));

endmodule

// File: tb/tb_sram6t_rram_prog_ctrl.sv
// tb_sram6t_rram_prog_ctrl: directed and random checks of the programming sequencer
module tb_sram6t_rram_prog_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v1 = 1'b0, ab1 = 1'b0, rdy1, busy1, done1;
    logic [0:0]  d1 = '0;
    logic [0:2]  bl1, wl1;

    logic        v2 = 1'b0, ab2 = 1'b0, rdy2, busy2, done2;
    logic [1:0]  d2 = '0;
    logic [0:2]  bl2;
    logic [0:5]  wl2;

    logic        v4 = 1'b0, ab4 = 1'b0, rdy4, busy4, done4;
    logic [3:0]  d4 = '0;
    logic [0:2]  bl4;
    logic [0:11] wl4;

    int checks = 0;
    int errors = 0;

    sram6t_rram_prog_ctrl #(.NUM_CELLS(1), .PULSE_CYCLES(2), .GAP_CYCLES(1)) u1 (
        .prog_clock(clk), .prog_reset_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .abort(ab1), .bl(bl1), .wl(wl1), .busy(busy1), .done(done1));

    sram6t_rram_prog_ctrl #(.NUM_CELLS(2), .PULSE_CYCLES(2), .GAP_CYCLES(1)) u2 (
        .prog_clock(clk), .prog_reset_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
        .abort(ab2), .bl(bl2), .wl(wl2), .busy(busy2), .done(done2));

    sram6t_rram_prog_ctrl #(.NUM_CELLS(4), .PULSE_CYCLES(3), .GAP_CYCLES(2)) u4 (
        .prog_clock(clk), .prog_reset_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
        .abort(ab4), .bl(bl4), .wl(wl4), .busy(busy4), .done(done4));

    // Expected outputs k cycles after the accept edge (k=1 is the first PH1 cycle).
    function automatic void model(input int n, input int p, input int g, input logic [3:0] w, input int k,
                                  output logic [0:2] e_bl, output logic [0:11] e_wl,
                                  output logic e_busy, output logic e_done);
        int len, c, pos;
        len    = 2*p + 2*g;
        c      = (k - 1) / len;
        pos    = (k - 1) % len;
        e_bl   = '0;
        e_wl   = '0;
        e_busy = (k >= 1) && (k <= n*len);
        e_done = (k == n*len + 1);
        if (e_busy && pos < p) begin
            e_bl = w[c] ? 3'b010 : 3'b100;
            e_wl[3*c + 2] = 1'b1;
        end else if (e_busy && pos >= p + g && pos < 2*p + g) begin
            e_bl = 3'b001;
            e_wl[3*c + (w[c] ? 1 : 0)] = 1'b1;
        end
    endfunction

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({rdy1, busy1, done1, bl1, wl1} !== 9'b0) begin
            errors++;
            $display("FAIL reset_u1 {ready,busy,done,bl,wl}: got %b required 0", {rdy1, busy1, done1, bl1, wl1});
        end
        checks++;
        if ({rdy2, busy2, done2, bl2, wl2} !== 12'b0) begin
            errors++;
            $display("FAIL reset_u2 {ready,busy,done,bl,wl}: got %b required 0", {rdy2, busy2, done2, bl2, wl2});
        end
        checks++;
        if ({rdy4, busy4, done4, bl4, wl4} !== 18'b0) begin
            errors++;
            $display("FAIL reset_u4 {ready,busy,done,bl,wl}: got %b required 0", {rdy4, busy4, done4, bl4, wl4});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy1, rdy2, rdy4} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release ready u1/u2/u4: got %b required 111", {rdy1, rdy2, rdy4});
        end
    endtask

    task automatic test_single_bit0;
        logic [0:2] exp_bl [1:7] = '{3'b100, 3'b100, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000};
        logic [0:2] exp_wl [1:7] = '{3'b001, 3'b001, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000};
        logic       exp_bz [1:7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       exp_dn [1:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        d1 = 1'b0;
        v1 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            v1 = 1'b0;
            checks++;
            if ({bl1, wl1} !== {exp_bl[k], exp_wl[k]}) begin
                errors++;
                $display("FAIL single_bit0 k=%0d bl/wl: got %b/%b required %b/%b", k, bl1, wl1, exp_bl[k], exp_wl[k]);
            end
            checks++;
            if ({busy1, done1} !== {exp_bz[k], exp_dn[k]}) begin
                errors++;
                $display("FAIL single_bit0 k=%0d busy/done: got %b/%b required %b/%b", k, busy1, done1, exp_bz[k], exp_dn[k]);
            end
        end
        @(negedge clk);
        checks++;
        if (rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL single_bit0 ready_after_done: got %b required 1", rdy1);
        end
    endtask

    task automatic test_two_cells;
        logic [0:2]  eb;
        logic [0:11] ew;
        logic        ebz, edn;
        logic [3:0]  w = 4'b0010;
        @(negedge clk);
        d2 = 2'b10;
        v2 = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            v2 = 1'b0;
            model(2, 2, 1, w, k, eb, ew, ebz, edn);
            checks++;
            if ({bl2, wl2, busy2, done2, rdy2} !== {eb, ew[0:5], ebz, edn, 1'b0}) begin
                errors++;
                $display("FAIL two_cells k=%0d {bl,wl,busy,done,ready}: got %b required %b",
                         k, {bl2, wl2, busy2, done2, rdy2}, {eb, ew[0:5], ebz, edn, 1'b0});
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [0:2]  eb;
        logic [0:11] ew;
        logic        ebz, edn;
        @(negedge clk);
        d2 = 2'b01;
        v2 = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 3) d2 = 2'b11;
            model(2, 2, 1, 4'b0001, k, eb, ew, ebz, edn);
            checks++;
            if ({bl2, wl2, busy2, done2, rdy2} !== {eb, ew[0:5], ebz, edn, 1'b0}) begin
                errors++;
                $display("FAIL back_to_back word1 k=%0d {bl,wl,busy,done,ready}: got %b required %b",
                         k, {bl2, wl2, busy2, done2, rdy2}, {eb, ew[0:5], ebz, edn, 1'b0});
            end
        end
        @(negedge clk);
        checks++;
        if ({rdy2, busy2} !== 2'b10) begin
            errors++;
            $display("FAIL back_to_back idle_gap ready/busy: got %b required 10", {rdy2, busy2});
        end
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            v2 = 1'b0;
            model(2, 2, 1, 4'b0011, k, eb, ew, ebz, edn);
            checks++;
            if ({bl2, wl2, busy2, done2, rdy2} !== {eb, ew[0:5], ebz, edn, 1'b0}) begin
                errors++;
                $display("FAIL back_to_back word2 k=%0d {bl,wl,busy,done,ready}: got %b required %b",
                         k, {bl2, wl2, busy2, done2, rdy2}, {eb, ew[0:5], ebz, edn, 1'b0});
            end
        end
    endtask

    task automatic test_abort;
        logic [0:2]  eb;
        logic [0:11] ew;
        logic        ebz, edn;
        int          pulses = 0;
        @(negedge clk);
        d2 = 2'b11;
        v2 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            v2 = 1'b0;
            model(2, 2, 1, 4'b0011, k, eb, ew, ebz, edn);
            checks++;
            if ({bl2, wl2, busy2} !== {eb, ew[0:5], ebz}) begin
                errors++;
                $display("FAIL abort_pre k=%0d {bl,wl,busy}: got %b required %b", k, {bl2, wl2, busy2}, {eb, ew[0:5], ebz});
            end
        end
        ab2 = 1'b1;
        @(negedge clk);
        ab2 = 1'b0;
        checks++;
        if ({bl2, wl2, busy2, done2, rdy2} !== 12'b000000000_001) begin
            errors++;
            $display("FAIL abort_next {bl,wl,busy,done,ready}: got %b required 000000000001", {bl2, wl2, busy2, done2, rdy2});
        end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done2) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_no_done pulses: got %0d required 0", pulses);
        end
        d2 = 2'b01;
        v2 = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            v2 = 1'b0;
            model(2, 2, 1, 4'b0001, k, eb, ew, ebz, edn);
            checks++;
            if ({bl2, wl2, busy2, done2} !== {eb, ew[0:5], ebz, edn}) begin
                errors++;
                $display("FAIL abort_resume k=%0d {bl,wl,busy,done}: got %b required %b", k, {bl2, wl2, busy2, done2}, {eb, ew[0:5], ebz, edn});
            end
        end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        @(negedge clk);
        d2 = 2'b00;
        v2 = 1'b1;
        repeat (3) @(negedge clk);
        v2 = 1'b0;
        checks++;
        if ({busy2, bl2} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_mid in_gap1 {busy,bl}: got %b required 1000", {busy2, bl2});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy2, busy2, done2, bl2, wl2} !== 12'b0) begin
            errors++;
            $display("FAIL reset_mid async {ready,busy,done,bl,wl}: got %b required 0", {rdy2, busy2, done2, bl2, wl2});
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy2, busy2} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid release ready/busy: got %b required 10", {rdy2, busy2});
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done2 || busy2 || bl2 != 3'b000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid no_resume active_cycles: got %0d required 0", bad);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 8; n++) begin
            logic [3:0] w = 4'($urandom);
            logic [3:0] p1 = ~w;
            logic [3:0] p2 = ~w;
            int done_at = 0;
            @(negedge clk);
            checks++;
            if (rdy4 !== 1'b1) begin
                errors++;
                $display("FAIL random word%0d ready: got %b required 1", n, rdy4);
            end
            d4 = w;
            v4 = 1'b1;
            for (int cyc = 1; cyc <= 60; cyc++) begin
                @(negedge clk);
                v4 = 1'b0;
                d4 = 4'($urandom);
                for (int i = 0; i < 12; i++)
                    if (wl4[i]) begin
                        if (bl4 == 3'b100) p1[i/3] = 1'b0;
                        if (bl4 == 3'b010) p1[i/3] = 1'b1;
                        if (bl4 == 3'b001) p2[i/3] = (i % 3 == 1);
                    end
                if (done4) begin
                    done_at = cyc;
                    break;
                end
            end
            checks++;
            if (done_at != 41) begin
                errors++;
                $display("FAIL random word%0d done_latency: got %0d required 41", n, done_at);
            end
            checks++;
            if (p1 !== w) begin
                errors++;
                $display("FAIL random word%0d ph1_bits: got %b required %b", n, p1, w);
            end
            checks++;
            if (p2 !== w) begin
                errors++;
                $display("FAIL random word%0d ph2_bits: got %b required %b", n, p2, w);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_bit0();
        test_two_cells();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram6t_rram_prog_ctrl.md
Name: sram6t_rram_prog_ctrl

Overview:
Programming sequencer that drives the bl/wl lines of a row of sram6T_rram cells on the configuration clock. It accepts a configuration word over a valid/ready handshake. Cells are programmed one at a time, each with the two-phase bl/wl pulse pattern for its data bit. It sits between the configuration-chain front end and the cell array, replacing hand-driven bl/wl stimulus.

Parameters:
NUM_CELLS, 4, number of cells programmed per word (>=1)
PULSE_CYCLES, 2, prog_clock cycles each programming phase is held (>=1)
GAP_CYCLES, 1, prog_clock cycles of all-zero bl/wl after each phase (>=1)

Ports:
prog_clock  input  1  programming clock; all logic on rising edge
prog_reset_n  input  1  asynchronous active-low reset
in_valid  input  1  configuration word valid
in_ready  output  1  controller can accept a word
in_data  input  NUM_CELLS  configuration bits; bit i programs cell i
abort  input  1  synchronous abort of the current word
bl  output  3  shared bit lines, bl[0] leftmost ([0:2] ordering)
wl  output  3*NUM_CELLS  word lines; cell i owns wl[3i +: 3], same [0:2] ordering
busy  output  1  high while a word is in progress
done  output  1  one-cycle pulse when a word completes

Behaviour:
- Reset (prog_reset_n=0, asynchronous): state IDLE; bl=0, wl=0, busy=0, done=0, in_ready=0 while reset is asserted. in_ready=1 from the first cycle after release.
- FSM states: IDLE, PH1, GAP1, PH2, GAP2, DONE. Cell index counter ranges 0..NUM_CELLS-1. Phase timer width is clog2(max(PULSE_CYCLES,GAP_CYCLES)+1).
- IDLE: in_ready=1. On in_valid & in_ready, latch in_data, set cell=0, go to PH1. in_valid without in_ready is ignored; the word is not latched.
- Bit 0 pattern:
  - PH1: bl=100, wl[cell]=001.
  - PH2: bl=001, wl[cell]=100.
- Bit 1 pattern:
  - PH1: bl=010, wl[cell]=001.
  - PH2: bl=001, wl[cell]=010.
- Phase timing: PH1/PH2 last PULSE_CYCLES cycles; GAP1/GAP2 last GAP_CYCLES cycles with bl=0 and wl=0. Order per bit is PH1 -> GAP1 -> PH2 -> GAP2.
- After GAP2: if cell<NUM_CELLS-1, increment cell and go to PH1. Otherwise go to DONE.
- DONE: done=1 for exactly one cycle, bl/wl=0, busy=0, in_ready=0. Then IDLE.
- busy=1 in PH1, GAP1, PH2, GAP2.
- Latency: PH1 outputs appear the cycle after the accept edge. done appears exactly NUM_CELLS*(2*PULSE_CYCLES+2*GAP_CYCLES) cycles after the first PH1 cycle.
- Output register: bl/wl are registered, with no combinational path from inputs to bl/wl.
- Invariants, checked by assertions:
  - At most one bl bit and one wl bit are high.
  - wl is nonzero only for the current cell.
  - bl and wl are both zero or both nonzero.
  - Each programming phase is preceded and followed by at least one all-zero cycle.
- abort: takes effect in any busy state, with priority over timer expiry. The next cycle is IDLE with bl=wl=0 and no done pulse. abort in IDLE/DONE is ignored.
- Reset mid-operation clears everything immediately, with no done pulse. The partially programmed word is not resumed.

Decomposition:
- Package sram6t_rram_prog_pkg holds:
  - state enum;
  - phase pattern constants BL_PH1_ZERO=100, BL_PH1_ONE=010, BL_PH2=001, WL_PH1=001, WL_PH2_ZERO=100, WL_PH2_ONE=010;
  - helper function cell_wl(bit, phase).
- One sub-module, sram6t_rram_prog_timer: loadable down-counter with a load value and a zero flag. It is shared by the pulse and gap phases.

Test Plan:
- NUM_CELLS=1, P=2, G=1, in_data=0 -> cycles 1-2 bl=100 wl=001; cycle 3 zero; cycles 4-5 bl=001 wl=100; cycle 6 zero; cycle 7 done=1.
- NUM_CELLS=2, in_data=2'b10 (cell1=1, cell0=0) -> cell0 gets bit-0 pattern on wl[0:2], then cell1 gets bl=010/wl[3:5]=001 then bl=001/wl[3:5]=010. done exactly 12 cycles after the first PH1.
- in_valid held high during busy with changing in_data -> no second accept until IDLE. The first word's pattern is unchanged and the second word is accepted the cycle after DONE.
- abort asserted in cell1 PH2 -> next cycle bl=wl=0, in_ready=1, done never pulses. A new word then programs normally from cell0.
- prog_reset_n pulsed low mid-GAP1 -> outputs zero asynchronously, without waiting for a clock edge. After release in_ready=1 and no done pulse.
- Random words, NUM_CELLS=4, P=3, G=2 -> scoreboard reconstructs each bit from its PH1/PH2 bl/wl patterns and matches in_data. All invariant assertions hold.
